// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller.
// The FSM state type and width helpers used by the controller and its return-address stack.
package interrupt_controller_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // $clog2 gives zero for n <= 1. That would produce zero-width vectors, so clamp it to 1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the interrupt-line identifier.
  function automatic int id_w(input int num_irq);
    return clog2_min1(num_irq);
  endfunction

  // Width of a stack occupancy count (0..depth inclusive).
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a stack slot index (0..depth-1).
  function automatic int slot_w(input int depth);
    return clog2_min1(depth);
  endfunction

endpackage

// File: rtl/interrupt_controller_stack.sv
// irq_stack: a LIFO of {return address, interrupt id} entries for nested service.
// Ports:
//   clk, rst              clock and asynchronous active-high reset (clears occupancy)
//   push, push_addr/id    push a new entry; accepted when not full or when popping in the same cycle
//   pop                   drop the top entry; ignored when empty
//   top_addr, top_id      top entry; address reads as 0 when empty
//   full, empty, count    occupancy status
module irq_stack
  import interrupt_controller_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ID_W       = 3,
  parameter int NEST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             push_addr,
  input  logic [ID_W-1:0]               push_id,
  output logic [DATA_W-1:0]             top_addr,
  output logic [ID_W-1:0]               top_id,
  output logic                          full,
  output logic                          empty,
  output logic [lvl_w(NEST_DEPTH)-1:0]  count
);
  localparam int LW = lvl_w(NEST_DEPTH);
  localparam int SW = slot_w(NEST_DEPTH);

  logic [DATA_W-1:0] r_addr_mem [NEST_DEPTH];
  logic [ID_W-1:0]   r_id_mem   [NEST_DEPTH];
  logic [LW-1:0]     r_count;

  logic          w_empty, w_full, w_do_pop, w_do_push;
  logic [SW-1:0] w_top_slot, w_wr_slot;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LW'(NEST_DEPTH));
  assign w_top_slot = SW'(r_count - LW'(1));
  assign w_do_pop   = pop & ~w_empty;
  // A pop and a push in the same cycle replace the top entry, even when the stack is full.
  assign w_do_push  = push & (~w_full | w_do_pop);
  assign w_wr_slot  = w_do_pop ? w_top_slot : SW'(r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_do_push && !w_do_pop) begin
      r_count <= r_count + LW'(1);
    end else if (w_do_pop && !w_do_push) begin
      r_count <= r_count - LW'(1);
    end
  end

  // Entry storage: only the occupancy count needs a reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr_mem[w_wr_slot] <= push_addr;
      r_id_mem[w_wr_slot]   <= push_id;
    end
  end

  assign top_addr = w_empty ? '0 : r_addr_mem[w_top_slot];
  assign top_id   = w_empty ? '0 : r_id_mem[w_top_slot];
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller with fixed priority (lowest index wins), vectored handler addresses,
// and a nesting stack of return addresses.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   irq_in                       interrupt lines (edge-latched or level, selected by EDGE_MODE)
//   mask_wr/mask_data            per-line enable write (1 = enabled)
//   vec_base_wr/vec_base_data    vector table base write
//   glob_mask/glob_unmask        clear / set the global enable
//   int_req/int_ack              request handshake with the control unit
//   int_id/int_addr              selected line and its handler address
//   ret_addr_in                  return address, pushed on int_ack
//   iret/ret_addr_out            handler return; top-of-stack return address
//   nest_level/stack_err         stack occupancy; sticky flag for a return on an empty stack
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ    = 8,
  parameter int DATA_W     = 16,
  parameter int NEST_DEPTH = 4,
  parameter int EDGE_MODE  = 1,
  parameter int VEC_STRIDE = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IRQ-1:0]            irq_in,
  input  logic                          mask_wr,
  input  logic [NUM_IRQ-1:0]            mask_data,
  input  logic                          vec_base_wr,
  input  logic [DATA_W-1:0]             vec_base_data,
  input  logic                          glob_mask,
  input  logic                          glob_unmask,
  output logic                          int_req,
  input  logic                          int_ack,
  output logic [id_w(NUM_IRQ)-1:0]      int_id,
  output logic [DATA_W-1:0]             int_addr,
  input  logic [DATA_W-1:0]             ret_addr_in,
  input  logic                          iret,
  output logic [DATA_W-1:0]             ret_addr_out,
  output logic [lvl_w(NEST_DEPTH)-1:0]  nest_level,
  output logic                          stack_err
);
  localparam int ID_W = id_w(NUM_IRQ);

  state_t              r_state, w_state_nxt;
  logic [NUM_IRQ-1:0]  r_irq_d, r_pend, r_mask;
  logic [DATA_W-1:0]   r_vec_base, r_addr;
  logic [ID_W-1:0]     r_id;
  logic                r_gie, r_stack_err;

  logic [NUM_IRQ-1:0]  w_rise, w_clr, w_elig, w_mask_nxt;
  logic [ID_W-1:0]     w_sel_id, w_top_id;
  logic [DATA_W-1:0]   w_sel_addr, w_top_addr;
  logic                w_any, w_load, w_push, w_ack_ok, w_iret_ok, w_gie_nxt;
  logic                w_full, w_empty;

  // Pending capture stage
  assign w_rise   = irq_in & ~r_irq_d;
  assign w_ack_ok = (r_state == S_REQ) & int_ack;
  // Acking a line clears its pending bit, but a new edge arriving in the same cycle wins.
  assign w_clr    = w_ack_ok ? (NUM_IRQ'(1) << r_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_d <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_d <= irq_in;
      if (EDGE_MODE != 0) r_pend <= (r_pend & ~w_clr) | w_rise;
      else                r_pend <= irq_in;
    end
  end

  // Configuration and global enable
  assign w_iret_ok  = iret & ~w_empty;
  assign w_mask_nxt = mask_wr ? mask_data : r_mask;

  always_comb begin
    w_gie_nxt = r_gie;
    if (glob_unmask || w_iret_ok) w_gie_nxt = 1'b1;
    if (glob_mask)                w_gie_nxt = 1'b0;
    if (w_ack_ok)                 w_gie_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask      <= '0;
      r_vec_base  <= '0;
      r_gie       <= 1'b0;
      r_stack_err <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      r_gie  <= w_gie_nxt;
      if (vec_base_wr)       r_vec_base  <= vec_base_data;
      if (iret && w_empty)   r_stack_err <= 1'b1;
    end
  end

  // Arbitration stage: a line must strictly outrank the in-service line to preempt it.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_elig[i] = r_pend[i] & r_mask[i] & r_gie & ~w_full &
                  (w_empty | (i < int'(w_top_id)));
    end
  end

  always_comb begin
    w_sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel_id = ID_W'(i);
    end
  end

  assign w_any      = |w_elig;
  assign w_sel_addr = r_vec_base + DATA_W'(w_sel_id) * DATA_W'(VEC_STRIDE);

  // Request FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!w_gie_nxt || !w_mask_nxt[r_id]) begin
          // Withdrawn before acceptance: the line stays pending and can be requested later.
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= '0;
      r_addr <= '0;
    end else if (w_load) begin
      r_id   <= w_sel_id;
      r_addr <= w_sel_addr;
    end
  end

  irq_stack #(
    .DATA_W     (DATA_W),
    .ID_W       (ID_W),
    .NEST_DEPTH (NEST_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_iret_ok),
    .push_addr (ret_addr_in),
    .push_id   (r_id),
    .top_addr  (w_top_addr),
    .top_id    (w_top_id),
    .full      (w_full),
    .empty     (w_empty),
    .count     (nest_level)
  );

  assign int_req      = (r_state == S_REQ);
  assign int_id       = r_id;
  assign int_addr     = r_addr;
  assign ret_addr_out = w_top_addr;
  assign stack_err    = r_stack_err;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller using the default parameters
// (8 lines, 16-bit addresses, depth 4, edge mode, stride 2).
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        mask_wr;
  logic [7:0]  mask_data;
  logic        vec_base_wr;
  logic [15:0] vec_base_data;
  logic        glob_mask, glob_unmask;
  logic        int_req, int_ack;
  logic [2:0]  int_id;
  logic [15:0] int_addr, ret_addr_in, ret_addr_out;
  logic        iret;
  logic [2:0]  nest_level;
  logic        stack_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  interrupt_controller #(
    .NUM_IRQ(8), .DATA_W(16), .NEST_DEPTH(4), .EDGE_MODE(1), .VEC_STRIDE(2)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr), .mask_data(mask_data),
    .vec_base_wr(vec_base_wr), .vec_base_data(vec_base_data),
    .glob_mask(glob_mask), .glob_unmask(glob_unmask),
    .int_req(int_req), .int_ack(int_ack), .int_id(int_id), .int_addr(int_addr),
    .ret_addr_in(ret_addr_in), .iret(iret), .ret_addr_out(ret_addr_out),
    .nest_level(nest_level), .stack_err(stack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    step();
    irq_in = '0;
  endtask

  task automatic ack_cyc(input logic [15:0] ret);
    int_ack     = 1'b1;
    ret_addr_in = ret;
    step();
    int_ack     = 1'b0;
  endtask

  task automatic iret_cyc();
    iret = 1'b1;
    step();
    iret = 1'b0;
  endtask

  task automatic unmask_cyc();
    glob_unmask = 1'b1;
    step();
    glob_unmask = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
    vec_base_wr = 1'b0; vec_base_data = '0; glob_mask = 1'b0; glob_unmask = 1'b0;
    int_ack = 1'b0; ret_addr_in = '0; iret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", int_req, 0);
    chk("rst_id", int_id, 0);
    chk("rst_addr", int_addr, 0);
    chk("rst_ret", ret_addr_out, 0);
    chk("rst_nest", nest_level, 0);
    chk("rst_err", stack_err, 0);
    rst = 1'b0;
    step();

    // Basic request: irq 3, vector base 0, latency of two cycles.
    mask_wr = 1'b1; mask_data = 8'hFF; glob_unmask = 1'b1;
    step();
    mask_wr = 1'b0; glob_unmask = 1'b0;
    pulse(8'h08);
    chk("lat_n1_req", int_req, 0);
    step();
    chk("lat_n2_req", int_req, 1);
    chk("irq3_id", int_id, 3);
    chk("irq3_addr", int_addr, 16'h0006);
    ack_cyc(16'h0100);
    chk("ack3_req", int_req, 0);
    chk("ack3_nest", nest_level, 1);
    chk("ack3_ret", ret_addr_out, 16'h0100);
    iret_cyc();
    chk("iret3_nest", nest_level, 0);
    chk("iret3_ret", ret_addr_out, 0);

    // Simultaneous irq 2 and 5: 2 first, then 5 after the return.
    pulse(8'h24);
    step();
    chk("pri_req", int_req, 1);
    chk("pri_id2", int_id, 2);
    chk("pri_addr2", int_addr, 16'h0004);
    ack_cyc(16'h0200);
    chk("pri_ack_req", int_req, 0);
    iret_cyc();
    chk("pri_iret_req", int_req, 0);
    step();
    chk("pri_req5", int_req, 1);
    chk("pri_id5", int_id, 5);
    chk("pri_addr5", int_addr, 16'h000A);
    ack_cyc(16'h0500);
    iret_cyc();

    // Preemption: 4 in service, 1 preempts, 6 waits for an empty stack.
    pulse(8'h10);
    step();
    chk("nest_id4", int_id, 4);
    ack_cyc(16'h0400);
    unmask_cyc();
    pulse(8'h40);
    step();
    chk("irq6_blocked", int_req, 0);
    pulse(8'h02);
    step();
    chk("pre_req1", int_req, 1);
    chk("pre_id1", int_id, 1);
    ack_cyc(16'h0410);
    chk("pre_nest2", nest_level, 2);
    chk("pre_ret", ret_addr_out, 16'h0410);
    unmask_cyc();
    step();
    chk("irq6_wait_a", int_req, 0);
    iret_cyc();
    chk("pre_nest1", nest_level, 1);
    chk("pre_ret4", ret_addr_out, 16'h0400);
    step();
    chk("irq6_wait_b", int_req, 0);
    iret_cyc();
    chk("pre_nest0", nest_level, 0);
    step();
    chk("irq6_req", int_req, 1);
    chk("irq6_id", int_id, 6);
    chk("irq6_addr", int_addr, 16'h000C);
    ack_cyc(16'h0600);
    iret_cyc();

    // Global mask while requesting withdraws the request; the line stays pending.
    pulse(8'h04);
    step();
    chk("gm_req", int_req, 1);
    glob_mask = 1'b1;
    step();
    glob_mask = 1'b0;
    chk("gm_drop", int_req, 0);
    chk("gm_nest", nest_level, 0);
    unmask_cyc();
    chk("gm_idle", int_req, 0);
    step();
    chk("gm_rereq", int_req, 1);
    chk("gm_id", int_id, 2);

    // New edge on line 2 in the same cycle as its ack keeps it pending.
    irq_in = 8'h04; int_ack = 1'b1; ret_addr_in = 16'h0220;
    step();
    irq_in = '0; int_ack = 1'b0;
    chk("ea_nest", nest_level, 1);
    chk("ea_req", int_req, 0);
    iret_cyc();
    step();
    chk("ea_pending", int_req, 1);
    chk("ea_id", int_id, 2);
    ack_cyc(16'h0230);
    iret_cyc();

    // Nest to full depth with ascending priorities; the fifth request is held off.
    for (int k = 7; k >= 4; k--) begin
      pulse(8'(1 << k));
      step();
      chk("fill_id", int_id, k);
      ack_cyc(16'(k << 8));
      unmask_cyc();
    end
    chk("full_nest", nest_level, 4);
    chk("full_ret", ret_addr_out, 16'h0400);
    pulse(8'h08);
    repeat (3) step();
    chk("full_block", int_req, 0);
    chk("full_nest_hold", nest_level, 4);
    iret_cyc();
    chk("full_pop_nest", nest_level, 3);
    chk("full_pop_ret", ret_addr_out, 16'h0500);
    step();
    chk("full_release", int_req, 1);
    chk("full_rel_id", int_id, 3);
    // Accept and return together: pop then push, depth unchanged.
    int_ack = 1'b1; iret = 1'b1; ret_addr_in = 16'h0300;
    step();
    int_ack = 1'b0; iret = 1'b0;
    chk("ackiret_nest", nest_level, 3);
    chk("ackiret_ret", ret_addr_out, 16'h0300);
    chk("ackiret_req", int_req, 0);
    repeat (3) iret_cyc();
    chk("unwind_nest", nest_level, 0);
    chk("unwind_ret", ret_addr_out, 0);
    chk("unwind_err", stack_err, 0);

    // Return on an empty stack sets a sticky error, cleared only by reset.
    iret_cyc();
    chk("uf_err", stack_err, 1);
    chk("uf_nest", nest_level, 0);
    step();
    chk("uf_sticky", stack_err, 1);
    rst = 1'b1;
    #1;
    chk("uf_rst_err", stack_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of a request; address wraps modulo 2^16.
    mask_wr = 1'b1; mask_data = 8'hFF; glob_unmask = 1'b1;
    vec_base_wr = 1'b1; vec_base_data = 16'hFFFE;
    step();
    mask_wr = 1'b0; glob_unmask = 1'b0; vec_base_wr = 1'b0;
    pulse(8'h08);
    step();
    chk("wrap_req", int_req, 1);
    chk("wrap_addr", int_addr, 16'h0004);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", int_req, 0);
    chk("mid_rst_id", int_id, 0);
    chk("mid_rst_addr", int_addr, 0);
    chk("mid_rst_nest", nest_level, 0);
    chk("mid_rst_ret", ret_addr_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_cyc(16'h0999);
    chk("late_ack_nest", nest_level, 0);
    chk("late_ack_req", int_req, 0);
    step();
    chk("late_ack_idle", int_req, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt lines (2..16).
REQ-002 Parameter DATA_W, default 16, address width.
REQ-003 Parameter NEST_DEPTH, default 4, maximum nesting depth (return-address stack entries).
REQ-004 Parameter EDGE_MODE, default 1: 1 = rising-edge latched, 0 = level-sensitive.
REQ-005 Parameter VEC_STRIDE, default 2, address distance between vector slots.
REQ-006 One clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 irq_in  in  NUM_IRQ  interrupt lines, synchronous to clk.
REQ-009 mask_wr / mask_data  in  1 / NUM_IRQ  per-line enable write (1 = enabled).
REQ-010 vec_base_wr / vec_base_data  in  1 / DATA_W  vector table base write.
REQ-011 glob_mask / glob_unmask  in  1 / 1  clear / set global enable.
REQ-012 int_req  out  1  request to control unit; int_ack  in  1  acceptance.
REQ-013 int_id  out  clog2(NUM_IRQ)  selected line; int_addr  out  DATA_W  handler address.
REQ-014 ret_addr_in  in  DATA_W  return address, captured on int_ack.
REQ-015 iret  in  1  handler return; ret_addr_out  out  DATA_W  top-of-stack return address.
REQ-016 nest_level  out  clog2(NEST_DEPTH+1)  stack occupancy; stack_err  out  1  sticky underflow flag.

Function
REQ-017 Edge mode: pending[i] set the cycle after irq_in[i] rises (one-register edge detect); cleared on ack of line i; latching ignores masks.
REQ-018 Level mode: pending[i] = registered irq_in[i]; never cleared by ack.
REQ-019 Eligible = pending & mask & global enable & stack not full & priority(i) strictly above in-service top (empty stack: all eligible).
REQ-020 Priority fixed: lowest index highest.
REQ-021 FSM IDLE -> REQ when any line eligible; int_id, int_addr registered at entry and frozen while in REQ.
REQ-022 REQ: int_req = 1; on int_ack push {ret_addr_in, int_id}, clear global enable, return to IDLE next cycle.
REQ-023 REQ with global enable cleared or chosen line masked before ack: int_req drops next cycle, return to IDLE, no push, pending retained.
REQ-024 int_addr = vec_base + int_id*VEC_STRIDE, truncated modulo 2^DATA_W.
REQ-025 Edge latency: irq_in rising sampled at cycle n -> int_req high at n+2.
REQ-026 iret pops top, sets global enable; ret_addr_out shows top before pop, 0 when empty.
REQ-027 iret on empty stack: ignored, stack_err set, held until reset.
REQ-028 int_ack and iret same cycle: pop then push; nest_level unchanged.
REQ-029 Stack full: no new int_req; pending lines wait.
REQ-030 Simultaneous edge and ack on same line: pending remains set.

Reset
REQ-031 rst asynchronously forces IDLE; int_req, int_id, int_addr, ret_addr_out, nest_level, stack_err = 0; pending, mask, vec_base, global enable, stack cleared.
REQ-032 Reset mid-REQ drops int_req immediately; late int_ack ignored.

Structure
REQ-033 Shared package: FSM state enum, clog2-derived width constants.
REQ-034 Sub-module irq_stack: NEST_DEPTH-entry LIFO of {DATA_W address, id} with push/pop/full/empty/count.

Verification
REQ-035 mask=0xFF, unmask, irq_in[3] rises cycle 10 -> int_req cycle 12, int_id=3, int_addr=0x0006 with vec_base 0.
REQ-036 irq 2 and 5 same cycle -> id 2 first; ack, iret -> id 5 served next.
REQ-037 In-service 4, irq 1 rises -> preempts, nest_level=2; irq 6 during service -> waits until stack empty.
REQ-038 NEST_DEPTH=4, five nested ascending-priority acks -> fifth int_req stays low, nest_level=4.
REQ-039 iret at empty stack -> stack_err=1, nest_level=0; rst -> stack_err=0.
REQ-040 rst mid-REQ (id 3) -> int_req=0 same cycle, all outputs 0, no push on later ack.
